// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a
// shared memory port with a ready handshake, counts retired instructions, halts on null/illegal.
module multicycle_ctrl #(
    parameter int CNT_W  = 32,
    parameter int RA_REG = 31
) (
    input  logic             clk,
    input  logic             resetN,
    input  logic [31:0]      instruction,
    input  logic             zero,
    input  logic             memReady,
    output logic             pcEn,
    output logic             iorD,
    output logic             memRead,
    output logic             memWrite,
    output logic             irWrite,
    output logic [1:0]       regDst,
    output logic [1:0]       memToReg,
    output logic             regWrite,
    output logic             aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic             extSel,
    output logic [2:0]       aluOp,
    output logic [1:0]       pcSource,
    output logic [3:0]       state,
    output logic [CNT_W-1:0] instCount,
    output logic             halted,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_RESET  = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_EXEC   = 4'd7,
        S_RWB    = 4'd8,  S_BRANCH = 4'd9, S_JUMP   = 4'd10, S_JR     = 4'd11,
        S_IEXEC  = 4'd12, S_IWB   = 4'd13, S_HALT   = 4'd15
    } state_t;

    localparam logic [5:0] OP_SPECIAL = 6'h00, OP_J   = 6'h02, OP_JAL  = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
    localparam logic [5:0] OP_ORI     = 6'h0D, OP_LW  = 6'h23, OP_SW   = 6'h2B;
    localparam logic [5:0] FN_JR  = 6'h08, FN_ADD = 6'h20, FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24, FN_OR  = 6'h25, FN_SLT = 6'h2A;

    // The datapath hard-wires regDst=2 to $31; a different link register is not supported.
    if (RA_REG != 31) begin : g_ra_check
        $error("multicycle_ctrl: RA_REG must be 31");
    end

    state_t           state_r, next_state_s;
    logic [CNT_W-1:0] inst_count_r;
    logic             illegal_r;
    logic             retire_s, set_illegal_s;
    logic [5:0]       opcode_s, funct_s;

    assign opcode_s = instruction[31:26];
    assign funct_s  = instruction[5:0];

    // Next-state, retire/illegal strobes and control outputs decoded from the current state.
    always_comb begin
        next_state_s  = state_r;
        retire_s      = 1'b0;
        set_illegal_s = 1'b0;
        pcEn = 1'b0;  iorD = 1'b0;  memRead = 1'b0;  memWrite = 1'b0;  irWrite = 1'b0;
        regDst = 2'd0;  memToReg = 2'd0;  regWrite = 1'b0;  aluSrcA = 1'b0;
        aluSrcB = 2'd0;  extSel = 1'b0;  aluOp = 3'b000;  pcSource = 2'd0;
        case (state_r)
            S_RESET: next_state_s = S_FETCH;
            S_FETCH: begin
                memRead = 1'b1;  aluSrcB = 2'd1;  aluOp = 3'b010;
                irWrite = memReady;  pcEn = memReady;
                if (memReady) next_state_s = S_DECODE;
                else          next_state_s = S_FETCH;
            end
            S_DECODE: begin
                aluSrcB = 2'd3;  aluOp = 3'b010;
                if (instruction == 32'h0000_0000) begin
                    next_state_s = S_HALT;
                end else begin
                    case (opcode_s)
                        OP_LW, OP_SW:   next_state_s = S_MEMADR;
                        OP_BEQ, OP_BNE: next_state_s = S_BRANCH;
                        OP_J, OP_JAL:   next_state_s = S_JUMP;
                        OP_ADDI, OP_ORI: next_state_s = S_IEXEC;
                        OP_SPECIAL: begin
                            case (funct_s)
                                FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: next_state_s = S_EXEC;
                                FN_JR:   next_state_s = S_JR;
                                default: begin
                                    next_state_s  = S_HALT;
                                    set_illegal_s = 1'b1;
                                end
                            endcase
                        end
                        default: begin
                            next_state_s  = S_HALT;
                            set_illegal_s = 1'b1;
                        end
                    endcase
                end
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;  aluSrcB = 2'd2;  aluOp = 3'b010;
                if (opcode_s == OP_LW) next_state_s = S_MEMRD;
                else                   next_state_s = S_MEMWR;
            end
            S_MEMRD: begin
                iorD = 1'b1;  memRead = 1'b1;
                if (memReady) next_state_s = S_MEMWB;
                else          next_state_s = S_MEMRD;
            end
            S_MEMWB: begin
                memToReg = 2'd1;  regWrite = 1'b1;
                retire_s = 1'b1;  next_state_s = S_FETCH;
            end
            S_MEMWR: begin
                iorD = 1'b1;  memWrite = 1'b1;
                if (memReady) begin
                    retire_s = 1'b1;  next_state_s = S_FETCH;
                end else begin
                    next_state_s = S_MEMWR;
                end
            end
            S_EXEC: begin
                aluSrcA = 1'b1;  next_state_s = S_RWB;
                case (funct_s)
                    FN_SUB:  aluOp = 3'b110;
                    FN_AND:  aluOp = 3'b000;
                    FN_OR:   aluOp = 3'b001;
                    FN_SLT:  aluOp = 3'b111;
                    default: aluOp = 3'b010;
                endcase
            end
            S_RWB: begin
                regDst = 2'd1;  regWrite = 1'b1;
                retire_s = 1'b1;  next_state_s = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;  aluOp = 3'b110;  pcSource = 2'd1;
                if (opcode_s == OP_BNE) pcEn = ~zero;
                else                    pcEn = zero;
                retire_s = 1'b1;  next_state_s = S_FETCH;
            end
            S_JUMP: begin
                pcSource = 2'd2;  pcEn = 1'b1;
                if (opcode_s == OP_JAL) begin
                    regDst = 2'd2;  memToReg = 2'd2;  regWrite = 1'b1;
                end else begin
                    regWrite = 1'b0;
                end
                retire_s = 1'b1;  next_state_s = S_FETCH;
            end
            S_JR: begin
                pcSource = 2'd3;  pcEn = 1'b1;
                retire_s = 1'b1;  next_state_s = S_FETCH;
            end
            S_IEXEC: begin
                aluSrcA = 1'b1;  aluSrcB = 2'd2;  next_state_s = S_IWB;
                if (opcode_s == OP_ORI) begin
                    extSel = 1'b1;  aluOp = 3'b001;
                end else begin
                    extSel = 1'b0;  aluOp = 3'b010;
                end
            end
            S_IWB: begin
                regWrite = 1'b1;
                retire_s = 1'b1;  next_state_s = S_FETCH;
            end
            S_HALT:  next_state_s = S_HALT;
            // Unused encoding 14 parks in HALT rather than running off.
            default: next_state_s = S_HALT;
        endcase
    end

    // State register, retired-instruction counter and sticky illegal flag.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_r      <= S_RESET;
            inst_count_r <= {CNT_W{1'b0}};
            illegal_r    <= 1'b0;
        end else begin
            state_r <= next_state_s;
            if (retire_s) inst_count_r <= inst_count_r + CNT_W'(1);
            if (set_illegal_s) illegal_r <= 1'b1;
        end
    end

    assign state     = state_r;
    assign instCount = inst_count_r;
    assign illegal   = illegal_r;
    assign halted    = (state_r == S_HALT);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed self-checking bench for multicycle_ctrl: state sequences, per-state controls,
// memory wait handling, halt/illegal, and asynchronous reset in the middle of a store.
module tb_multicycle_ctrl;

    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic [31:0] instruction = 32'h0;
    logic        zero = 1'b0;
    logic        memReady = 1'b1;
    logic        pcEn, iorD, memRead, memWrite, irWrite, regWrite, aluSrcA, extSel;
    logic        halted, illegal;
    logic [1:0]  regDst, memToReg, aluSrcB, pcSource;
    logic [2:0]  aluOp;
    logic [3:0]  state;
    logic [31:0] instCount;
    int          checks = 0;
    int          errors = 0;

    multicycle_ctrl #(.CNT_W(32), .RA_REG(31)) dut (
        .clk(clk), .resetN(resetN), .instruction(instruction), .zero(zero),
        .memReady(memReady), .pcEn(pcEn), .iorD(iorD), .memRead(memRead),
        .memWrite(memWrite), .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg),
        .regWrite(regWrite), .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .extSel(extSel),
        .aluOp(aluOp), .pcSource(pcSource), .state(state), .instCount(instCount),
        .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // Reset pulse then release on a falling edge; FETCH appears after the next rising edge.
    task automatic do_reset(input logic [31:0] instr);
        @(negedge clk);
        resetN = 1'b0;  memReady = 1'b1;  zero = 1'b0;  instruction = instr;
        @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic test_reset;
        @(negedge clk);
        resetN = 1'b0;  instruction = 32'h012A4020;  memReady = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0 || instCount !== 32'd0 || illegal !== 1'b0 || halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: state=%0d cnt=%0d ill=%b halt=%b required 0,0,0,0",
                     state, instCount, illegal, halted);
        end
        checks++;
        if ({pcEn, iorD, memRead, memWrite, irWrite, regWrite, aluSrcA, extSel, regDst,
             memToReg, aluSrcB, aluOp, pcSource} !== 19'd0) begin
            errors++;
            $display("FAIL reset_outputs: some control nonzero, required all 0");
        end
    endtask

    task automatic test_rtype;
        logic [3:0] exp [5] = '{4'd1, 4'd2, 4'd7, 4'd8, 4'd1};
        do_reset(32'h012A4020);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            checks++;
            if (state !== exp[i]) begin
                errors++;
                $display("FAIL rtype_state[%0d]: got %0d required %0d", i, state, exp[i]);
            end
            checks++;
            if (regWrite !== (exp[i] == 4'd8) || regDst !== ((exp[i] == 4'd8) ? 2'd1 : 2'd0)) begin
                errors++;
                $display("FAIL rtype_wb[%0d]: regWrite=%b regDst=%0d", i, regWrite, regDst);
            end
            if (exp[i] == 4'd1) begin
                checks++;
                if (irWrite !== 1'b1 || pcEn !== 1'b1 || memRead !== 1'b1 || aluSrcB !== 2'd1) begin
                    errors++;
                    $display("FAIL rtype_fetch: ir=%b pcEn=%b mr=%b srcB=%0d required 1,1,1,1",
                             irWrite, pcEn, memRead, aluSrcB);
                end
            end
            if (exp[i] == 4'd7) begin
                checks++;
                if (aluOp !== 3'b010 || aluSrcA !== 1'b1 || aluSrcB !== 2'd0) begin
                    errors++;
                    $display("FAIL rtype_exec: aluOp=%b srcA=%b srcB=%0d required 010,1,0",
                             aluOp, aluSrcA, aluSrcB);
                end
            end
        end
        checks++;
        if (instCount !== 32'd1) begin
            errors++;
            $display("FAIL rtype_count: got %0d required 1", instCount);
        end
    endtask

    task automatic test_lw_wait;
        logic [3:0] exp [9] = '{4'd1, 4'd1, 4'd2, 4'd3, 4'd4, 4'd4, 4'd4, 4'd5, 4'd1};
        logic       mr  [9] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        do_reset(32'h8D090004);
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            memReady = mr[i];
            #1;
            checks++;
            if (state !== exp[i]) begin
                errors++;
                $display("FAIL lw_state[%0d]: got %0d required %0d", i, state, exp[i]);
            end
            if (i == 0) begin
                checks++;
                if (irWrite !== 1'b0 || pcEn !== 1'b0 || memRead !== 1'b1) begin
                    errors++;
                    $display("FAIL lw_fetch_wait: ir=%b pcEn=%b mr=%b required 0,0,1",
                             irWrite, pcEn, memRead);
                end
            end
            if (exp[i] == 4'd3) begin
                checks++;
                if (aluSrcA !== 1'b1 || aluSrcB !== 2'd2 || extSel !== 1'b0 || aluOp !== 3'b010) begin
                    errors++;
                    $display("FAIL lw_memadr: srcA=%b srcB=%0d ext=%b op=%b", aluSrcA, aluSrcB,
                             extSel, aluOp);
                end
            end
            if (exp[i] == 4'd4) begin
                checks++;
                if (iorD !== 1'b1 || memRead !== 1'b1 || regWrite !== 1'b0) begin
                    errors++;
                    $display("FAIL lw_memrd[%0d]: iorD=%b mr=%b rw=%b required 1,1,0", i, iorD,
                             memRead, regWrite);
                end
            end
            if (exp[i] == 4'd5) begin
                checks++;
                if (regWrite !== 1'b1 || memToReg !== 2'd1 || regDst !== 2'd0) begin
                    errors++;
                    $display("FAIL lw_memwb: rw=%b m2r=%0d rd=%0d required 1,1,0", regWrite,
                             memToReg, regDst);
                end
            end
        end
        checks++;
        if (instCount !== 32'd1) begin
            errors++;
            $display("FAIL lw_count: got %0d required 1", instCount);
        end
    endtask

    // BEQ taken then BNE not taken, issued back to back without a reset in between.
    task automatic test_back_to_back_branch;
        do_reset(32'h11090003);
        zero = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        checks++;
        if (state !== 4'd9 || pcEn !== 1'b1 || pcSource !== 2'd1 || aluOp !== 3'b110) begin
            errors++;
            $display("FAIL beq_branch: state=%0d pcEn=%b src=%0d op=%b required 9,1,1,110",
                     state, pcEn, pcSource, aluOp);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1 || instCount !== 32'd1) begin
            errors++;
            $display("FAIL beq_retire: state=%0d cnt=%0d required 1,1", state, instCount);
        end
        instruction = 32'h15090003;
        @(negedge clk); @(negedge clk); #1;
        checks++;
        if (state !== 4'd9 || pcEn !== 1'b0 || pcSource !== 2'd1) begin
            errors++;
            $display("FAIL bne_branch: state=%0d pcEn=%b src=%0d required 9,0,1", state, pcEn,
                     pcSource);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1 || instCount !== 32'd2) begin
            errors++;
            $display("FAIL bne_retire: state=%0d cnt=%0d required 1,2", state, instCount);
        end
    endtask

    task automatic test_jal;
        do_reset(32'h0C100008);
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        checks++;
        if (state !== 4'd10 || pcEn !== 1'b1 || pcSource !== 2'd2 || regDst !== 2'd2 ||
            memToReg !== 2'd2 || regWrite !== 1'b1) begin
            errors++;
            $display("FAIL jal_jump: state=%0d pcEn=%b src=%0d rd=%0d m2r=%0d rw=%b", state,
                     pcEn, pcSource, regDst, memToReg, regWrite);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1 || instCount !== 32'd1) begin
            errors++;
            $display("FAIL jal_next: state=%0d cnt=%0d required 1,1", state, instCount);
        end
    endtask

    task automatic test_ori;
        do_reset(32'h3508000F);
        @(negedge clk); @(negedge clk); @(negedge clk); #1;
        checks++;
        if (state !== 4'd12 || extSel !== 1'b1 || aluOp !== 3'b001 || aluSrcA !== 1'b1 ||
            aluSrcB !== 2'd2) begin
            errors++;
            $display("FAIL ori_iexec: state=%0d ext=%b op=%b srcA=%b srcB=%0d", state, extSel,
                     aluOp, aluSrcA, aluSrcB);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd13 || regWrite !== 1'b1 || regDst !== 2'd0 || memToReg !== 2'd0) begin
            errors++;
            $display("FAIL ori_iwb: state=%0d rw=%b rd=%0d m2r=%0d", state, regWrite, regDst,
                     memToReg);
        end
    endtask

    task automatic test_halt;
        do_reset(32'h0000_0000);
        @(negedge clk); @(negedge clk); @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if (state !== 4'd15 || halted !== 1'b1 || illegal !== 1'b0 || memRead !== 1'b0 ||
                instCount !== 32'd0) begin
                errors++;
                $display("FAIL halt_null[%0d]: state=%0d halted=%b ill=%b mr=%b cnt=%0d", i,
                         state, halted, illegal, memRead, instCount);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_illegal;
        logic [31:0] bad [2] = '{32'hFC00_0000, 32'h0000_000C};
        for (int k = 0; k < 2; k++) begin
            do_reset(bad[k]);
            @(negedge clk); @(negedge clk); @(negedge clk); #1;
            checks++;
            if (state !== 4'd15 || halted !== 1'b1 || illegal !== 1'b1) begin
                errors++;
                $display("FAIL illegal[%0d]: state=%0d halted=%b ill=%b required 15,1,1", k,
                         state, halted, illegal);
            end
        end
    endtask

    task automatic test_reset_mid_access;
        do_reset(32'h012A4020);
        for (int i = 0; i < 5; i++) @(negedge clk);
        instruction = 32'hAD090004;
        #1;
        checks++;
        if (state !== 4'd1 || instCount !== 32'd1) begin
            errors++;
            $display("FAIL mid_pre: state=%0d cnt=%0d required 1,1", state, instCount);
        end
        @(negedge clk); @(negedge clk); @(negedge clk);
        memReady = 1'b0;
        #1;
        checks++;
        if (state !== 4'd6 || memWrite !== 1'b1 || iorD !== 1'b1) begin
            errors++;
            $display("FAIL mid_memwr: state=%0d mw=%b iorD=%b required 6,1,1", state, memWrite,
                     iorD);
        end
        #1 resetN = 1'b0;
        #1;
        checks++;
        if (state !== 4'd0 || memWrite !== 1'b0 || instCount !== 32'd0) begin
            errors++;
            $display("FAIL mid_async: state=%0d mw=%b cnt=%0d required 0,0,0", state, memWrite,
                     instCount);
        end
        @(negedge clk);
        resetN = 1'b1;  memReady = 1'b1;
        #1;
        checks++;
        if (state !== 4'd0) begin
            errors++;
            $display("FAIL mid_release: state=%0d required 0", state);
        end
        @(negedge clk); #1;
        checks++;
        if (state !== 4'd1 || instCount !== 32'd0) begin
            errors++;
            $display("FAIL mid_fetch: state=%0d cnt=%0d required 1,0", state, instCount);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_wait();
        test_back_to_back_branch();
        test_jal();
        test_ori();
        test_halt();
        test_illegal();
        test_reset_mid_access();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
